// File: rtl/rs_station.sv
// Reservation station for the EX unit: buffers decoded instructions, snoops the
// EX and LSB result buses for pending operands, and issues the lowest-index
// ready entry each cycle through a registered output (the execute-stage register).
module rs_station #(
  parameter int unsigned RS_SIZE      = 16,
  parameter int unsigned RS_IDX_W     = 4,
  parameter int unsigned InstrIdWidth = 6,
  parameter int unsigned ImmWidth     = 32,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned ROBIdxWidth  = 4,
  parameter int unsigned WordWidth    = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear_in,
  input  logic                    dispatch_en_in,
  input  logic [InstrIdWidth-1:0] instr_id_in,
  input  logic [ImmWidth-1:0]     imm_in,
  input  logic [AddrWidth-1:0]    pc_in,
  input  logic [ROBIdxWidth-1:0]  rob_pos_in,
  input  logic                    qj_busy_in,
  input  logic                    qk_busy_in,
  input  logic [ROBIdxWidth-1:0]  qj_in,
  input  logic [ROBIdxWidth-1:0]  qk_in,
  input  logic [WordWidth-1:0]    vj_in,
  input  logic [WordWidth-1:0]    vk_in,
  input  logic                    ex_cdb_en_in,
  input  logic                    lsb_cdb_en_in,
  input  logic [ROBIdxWidth-1:0]  ex_cdb_rob_pos_in,
  input  logic [ROBIdxWidth-1:0]  lsb_cdb_rob_pos_in,
  input  logic [WordWidth-1:0]    ex_cdb_res_in,
  input  logic [WordWidth-1:0]    lsb_cdb_res_in,
  output logic                    full_out,
  output logic                    rs_to_ex_en_out,
  output logic [InstrIdWidth-1:0] instr_id_out,
  output logic [ImmWidth-1:0]     imm_out,
  output logic [WordWidth-1:0]    rs1_out,
  output logic [WordWidth-1:0]    rs2_out,
  output logic [AddrWidth-1:0]    pc_out,
  output logic [ROBIdxWidth-1:0]  rob_pos_out
);

  // Entry state; only the busy bits carry reset, payload is qualified by busy.
  logic [RS_SIZE-1:0]      busy_q, busy_d, qjb_q, qjb_d, qkb_q, qkb_d, ready;
  logic [InstrIdWidth-1:0] id_q  [RS_SIZE], id_d  [RS_SIZE];
  logic [ImmWidth-1:0]     imm_q [RS_SIZE], imm_d [RS_SIZE];
  logic [AddrWidth-1:0]    pc_q  [RS_SIZE], pc_d  [RS_SIZE];
  logic [ROBIdxWidth-1:0]  rob_q [RS_SIZE], rob_d [RS_SIZE];
  logic [ROBIdxWidth-1:0]  qj_q  [RS_SIZE], qj_d  [RS_SIZE];
  logic [ROBIdxWidth-1:0]  qk_q  [RS_SIZE], qk_d  [RS_SIZE];
  logic [WordWidth-1:0]    vj_q  [RS_SIZE], vj_d  [RS_SIZE];
  logic [WordWidth-1:0]    vk_q  [RS_SIZE], vk_d  [RS_SIZE];

  // Issue register
  logic                    en_q, en_d;
  logic [InstrIdWidth-1:0] oid_q, oid_d;
  logic [ImmWidth-1:0]     oimm_q, oimm_d;
  logic [WordWidth-1:0]    ors1_q, ors1_d, ors2_q, ors2_d;
  logic [AddrWidth-1:0]    opc_q, opc_d;
  logic [ROBIdxWidth-1:0]  orob_q, orob_d;

  logic                    issue_found;
  logic [RS_IDX_W-1:0]     issue_idx, free_idx;
  logic                    disp_qjb, disp_qkb;
  logic [WordWidth-1:0]    disp_vj, disp_vk;

  assign ready    = busy_q & ~qjb_q & ~qkb_q;
  assign full_out = &busy_q;

  assign rs_to_ex_en_out = en_q;
  assign instr_id_out    = oid_q;
  assign imm_out         = oimm_q;
  assign rs1_out         = ors1_q;
  assign rs2_out         = ors2_q;
  assign pc_out          = opc_q;
  assign rob_pos_out     = orob_q;

  // Lowest-index ready entry and lowest-index free entry, from pre-edge state.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = RS_IDX_W'(i);
      end
      if (!busy_q[i]) free_idx = RS_IDX_W'(i);
    end
  end

  // Snoop the buses for the incoming operands so a same-cycle broadcast is caught.
  always_comb begin
    disp_qjb = qj_busy_in;
    disp_vj  = vj_in;
    disp_qkb = qk_busy_in;
    disp_vk  = vk_in;
    if (qj_busy_in) begin
      if (ex_cdb_en_in && ex_cdb_rob_pos_in == qj_in) begin
        disp_qjb = 1'b0;
        disp_vj  = ex_cdb_res_in;
      end else if (lsb_cdb_en_in && lsb_cdb_rob_pos_in == qj_in) begin
        disp_qjb = 1'b0;
        disp_vj  = lsb_cdb_res_in;
      end
    end
    if (qk_busy_in) begin
      if (ex_cdb_en_in && ex_cdb_rob_pos_in == qk_in) begin
        disp_qkb = 1'b0;
        disp_vk  = ex_cdb_res_in;
      end else if (lsb_cdb_en_in && lsb_cdb_rob_pos_in == qk_in) begin
        disp_qkb = 1'b0;
        disp_vk  = lsb_cdb_res_in;
      end
    end
  end

  // Next state: flush, wakeup, issue and dispatch; everything holds while rdy_in is low.
  always_comb begin
    busy_d = busy_q;
    qjb_d  = qjb_q;
    qkb_d  = qkb_q;
    id_d   = id_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    rob_d  = rob_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    en_d   = en_q;
    oid_d  = oid_q;
    oimm_d = oimm_q;
    ors1_d = ors1_q;
    ors2_d = ors2_q;
    opc_d  = opc_q;
    orob_d = orob_q;
    if (rdy_in) begin
      if (clear_in) begin
        busy_d = '0;
        en_d   = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && qjb_q[i]) begin
            if (ex_cdb_en_in && ex_cdb_rob_pos_in == qj_q[i]) begin
              qjb_d[i] = 1'b0;
              vj_d[i]  = ex_cdb_res_in;
            end else if (lsb_cdb_en_in && lsb_cdb_rob_pos_in == qj_q[i]) begin
              qjb_d[i] = 1'b0;
              vj_d[i]  = lsb_cdb_res_in;
            end
          end
          if (busy_q[i] && qkb_q[i]) begin
            if (ex_cdb_en_in && ex_cdb_rob_pos_in == qk_q[i]) begin
              qkb_d[i] = 1'b0;
              vk_d[i]  = ex_cdb_res_in;
            end else if (lsb_cdb_en_in && lsb_cdb_rob_pos_in == qk_q[i]) begin
              qkb_d[i] = 1'b0;
              vk_d[i]  = lsb_cdb_res_in;
            end
          end
        end
        en_d = issue_found;
        if (issue_found) begin
          oid_d             = id_q[issue_idx];
          oimm_d            = imm_q[issue_idx];
          ors1_d            = vj_q[issue_idx];
          ors2_d            = vk_q[issue_idx];
          opc_d             = pc_q[issue_idx];
          orob_d            = rob_q[issue_idx];
          busy_d[issue_idx] = 1'b0;
        end
        // free_idx is never the issuing entry, so a freed slot waits a cycle.
        if (dispatch_en_in && !full_out) begin
          busy_d[free_idx] = 1'b1;
          id_d[free_idx]   = instr_id_in;
          imm_d[free_idx]  = imm_in;
          pc_d[free_idx]   = pc_in;
          rob_d[free_idx]  = rob_pos_in;
          qj_d[free_idx]   = qj_in;
          qk_d[free_idx]   = qk_in;
          qjb_d[free_idx]  = disp_qjb;
          qkb_d[free_idx]  = disp_qkb;
          vj_d[free_idx]   = disp_vj;
          vk_d[free_idx]   = disp_vk;
        end
      end
    end
  end

  // Busy bits and issue register, asynchronously reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      en_q   <= 1'b0;
      oid_q  <= '0;
      oimm_q <= '0;
      ors1_q <= '0;
      ors2_q <= '0;
      opc_q  <= '0;
      orob_q <= '0;
    end else begin
      busy_q <= busy_d;
      en_q   <= en_d;
      oid_q  <= oid_d;
      oimm_q <= oimm_d;
      ors1_q <= ors1_d;
      ors2_q <= ors2_d;
      opc_q  <= opc_d;
      orob_q <= orob_d;
    end
  end

  // Entry payload, meaningful only while the entry is busy.
  always_ff @(posedge clk_in) begin
    qjb_q <= qjb_d;
    qkb_q <= qkb_d;
    id_q  <= id_d;
    imm_q <= imm_d;
    pc_q  <= pc_d;
    rob_q <= rob_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
  end

endmodule
